// File: rtl/alu_ctrl_pkg.sv
// Package: alu_ctrl_pkg
// Shared definitions for the ALU arbiter slice: the ALU opcode encoding, the
// nominal ALU datapath width and opcode classification helpers.
package alu_ctrl_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101
  } alu_op_t;

  // Encodings 110 and 111 are unused by the ALU and reported as errors.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= 3'b101);
  endfunction

  // Only arithmetic results carry a meaningful sign.
  function automatic logic is_arith_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Interface: alu_arbiter_if
// Bundles the requester handshakes, the external ALU operand/result ports and
// the registered response channel of alu_arbiter.
//   req_valid/req_ready : per-requester handshake, one bit per requester
//   req_a/req_b/req_op  : packed requester fields, requester i at slot i
//   alu_a/alu_b/alu_op  : operands/opcode to the external ALU
//   alu_result          : combinational ALU result
//   rsp_*               : registered response with id and Z/N/err flags
//   op_count            : saturating count of completed responses
// Modports: slave = the arbiter, master = the surrounding environment
// (issue logic, ALU and response consumer).
interface alu_arbiter_if
  import alu_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = ALU_WIDTH,
  parameter int CNT_W   = 16
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*3-1:0]     req_op;
  logic [WIDTH-1:0]         alu_a;
  logic [WIDTH-1:0]         alu_b;
  logic [2:0]               alu_op;
  logic [WIDTH-1:0]         alu_result;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_result;
  logic [ID_W-1:0]          rsp_id;
  logic                     rsp_zero;
  logic                     rsp_neg;
  logic                     rsp_err;
  logic [CNT_W-1:0]         op_count;

  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op,
    output rsp_valid, rsp_result, rsp_id, rsp_zero, rsp_neg, rsp_err, op_count
  );

  modport master (
    output req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_result, rsp_id, rsp_zero, rsp_neg, rsp_err, op_count
  );

endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// Module: rr_arbiter
// Round-robin arbiter with its own rotating priority pointer.
//   clk, rst : clock and asynchronous active-high reset (pointer -> 0)
//   req      : request vector
//   advance  : the current winner was accepted; move priority past it
//   grant    : one-hot winner (zero when nothing requests)
//   idx      : binary index of the winner
//   any      : at least one request present
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N-1:0]                       req,
  input  logic                               advance,
  output logic [N-1:0]                       grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx,
  output logic                               any
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [IW-1:0] ptr;

  // Scan from the pointer, wrapping once; the first requester found wins.
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j[IW-1:0];
      end
    end
  end

  // Explicit wrap because N need not be a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Module: alu_arbiter
// Shares one external combinational ALU between NUM_REQ requesters. A
// round-robin arbiter picks one valid requester per cycle and routes its
// operands to the ALU; the result is captured into a single response register
// together with the requester id and zero/negative/error flags.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : alu_arbiter_if slave modport (requests, ALU ports, response,
//              completed-operation counter)
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = ALU_WIDTH,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  alu_arbiter_if.slave bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    win_idx;
  logic               any_valid;
  logic               can_accept;
  logic               accept;
  logic               rsp_hs;

  logic [WIDTH-1:0]        a_p0;
  logic [WIDTH-1:0]        b_p0;
  logic [2:0]              op_p0;
  logic                    legal_p0;
  logic signed [WIDTH-1:0] res_p0;
  logic                    neg_p0;

  logic [0:0]              state_p1;
  logic signed [WIDTH-1:0] res_p1;
  logic [ID_W-1:0]         id_p1;
  logic                    zero_p1;
  logic                    neg_p1;
  logic                    err_p1;
  logic [CNT_W-1:0]        cnt_p1;

  // ---- stage p0: arbitration and ALU operand routing ----
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .advance (accept),
    .grant   (grant),
    .idx     (win_idx),
    .any     (any_valid)
  );

  // The held response can be replaced in the same cycle it is consumed.
  assign can_accept = (state_p1 == EMPTY) || bus.rsp_ready;
  assign accept     = any_valid && can_accept && !rst;
  assign rsp_hs     = (state_p1 == FULL) && bus.rsp_ready;

  assign bus.req_ready = accept ? grant : '0;

  always_comb begin
    a_p0  = '0;
    b_p0  = '0;
    op_p0 = 3'b000;
    if (any_valid) begin
      a_p0  = bus.req_a[win_idx*WIDTH +: WIDTH];
      b_p0  = bus.req_b[win_idx*WIDTH +: WIDTH];
      op_p0 = bus.req_op[win_idx*3 +: 3];
    end
  end

  assign bus.alu_a  = a_p0;
  assign bus.alu_b  = b_p0;
  assign bus.alu_op = op_p0;

  // Illegal opcodes report a clean zero regardless of what the ALU drives.
  assign legal_p0 = is_legal_op(op_p0);
  assign res_p0   = legal_p0 ? $signed(bus.alu_result) : '0;
  assign neg_p0   = is_arith_op(op_p0) && (res_p0 < 0);

  // ---- stage p1: registered response ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1 <= EMPTY;
      res_p1   <= '0;
      id_p1    <= '0;
      zero_p1  <= 1'b0;
      neg_p1   <= 1'b0;
      err_p1   <= 1'b0;
      cnt_p1   <= '0;
    end else begin
      if (accept) begin
        state_p1 <= FULL;
        res_p1   <= res_p0;
        id_p1    <= win_idx;
        zero_p1  <= (res_p0 == '0);
        neg_p1   <= neg_p0;
        err_p1   <= !legal_p0;
      end else if (rsp_hs) begin
        state_p1 <= EMPTY;
      end
      if (rsp_hs) begin
        cnt_p1 <= sat_inc(cnt_p1);
      end
    end
  end

  assign bus.rsp_valid  = (state_p1 == FULL);
  assign bus.rsp_result = res_p1;
  assign bus.rsp_id     = id_p1;
  assign bus.rsp_zero   = zero_p1;
  assign bus.rsp_neg    = neg_p1;
  assign bus.rsp_err    = err_p1;
  assign bus.op_count   = cnt_p1;

endmodule
